md5_job_sequencer: RTL and testbench
====================================

// Module: md5_job_sequencer
// PURPOSE
//  Sequences one hash-search job through string_process_match: latches job config, pulses proc_start,
//  meters exactly job_num_bytes bytes into the hasher, and waits for proc_done with a timeout.
//  It then reports match/position, and on a match streams the matched string out one char per handshake.
//  Sits between cmd_parser and string_process_match; one job in flight.
// PARAMETERS
//  MAX_STR_BYTES   55    largest legal string, bytes (fits 448-bit msg incl. pad bit)
//  TIMEOUT_CYCLES  4096  max cycles in WAIT for proc_done before aborting
// PORTS
//  clk                 in   1    clock
//  reset               in   1    synchronous, active-high reset
//  job_valid/job_ready in/out 1  job handshake
//  job_num_bytes       in   16   bytes (= hashes) in job
//  job_str_len         in   16   string length in bits (proc_str_len format)
//  job_target_hash     in   128  target digest {a,b,c,d}
//  in_data             in   8    byte stream from host
//  in_valid/in_ready   in/out 1  byte handshake
//  proc_start          out  1    1-cycle pulse to matcher
//  proc_num_bytes      out  16   latched job_num_bytes
//  proc_str_len        out  16   latched job_str_len
//  proc_target_hash    out  128  latched job_target_hash
//  proc_data           out  8    = in_data
//  proc_data_valid     out  1    = in_valid & in_ready
//  proc_match_char_next out 1    1-cycle shift pulse to matcher
//  proc_done, proc_match in 1    matcher status (level)
//  proc_byte_pos       in   16   matcher hit position
//  proc_match_char     in   8    current head char of matched string
//  res_valid/res_ready out/in 1  result handshake
//  res_match, res_timeout, res_error out 1  result flags
//  res_byte_pos        out  16   hit position (0 if no match)
//  char_data           out  8    matched char
//  char_valid/char_ready out/in 1  char handshake
//  char_last           out  1    marks final char
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0 except job_ready=1. Latched regs 0. Reset mid-job aborts to IDLE next cycle.
//  States: IDLE->START->GUARD->FEED->WAIT->REPORT->CHARS->IDLE.
//  IDLE: job_ready=1. On job_valid, latch config.
//   - str_len==0, str_len%8!=0, or str_len>MAX_STR_BYTES*8: REPORT with res_error=1 (no proc_start).
//   - else: START.
//  START: proc_start=1 for exactly one cycle. GUARD: one cycle; proc_done ignored in START/GUARD (stale level).
//  FEED: in_ready=1; 16b counter counts handshakes; after job_num_bytes-th byte -> WAIT.
//   job_num_bytes==0 skips FEED (GUARD->WAIT).
//  WAIT: in_ready=0; cycle counter from 0.
//   - proc_done=1 -> capture proc_match, proc_byte_pos; REPORT.
//   - counter==TIMEOUT_CYCLES-1 with no done -> res_timeout=1, res_match=0, REPORT.
//   - done and timeout same cycle: done wins.
//  REPORT: res_valid held with stable flags until res_ready.
//   - On handshake: CHARS if res_match=1, else IDLE.
//  CHARS: n=str_len/8 chars. char_data=proc_match_char.
//   - On char handshake: pulse proc_match_char_next; char_valid deasserts the following cycle (matcher shift
//     latency), so at most one char per 2 cycles.
//   - char_last=1 on char n; after its handshake -> IDLE.
//  job_ready=0 in every state but IDLE; res_* and char_* flags cleared on leaving their state.
// TESTING
//  1 Reset: hold reset 3 cycles -> all outputs 0, job_ready=1, no proc_start.
//  2 Match: N=4, str_len=24, stub done with match, pos=2, chars "abc" -> 1 start pulse, exactly 4 proc_data_valid;
//    res_match=1, pos=2; chars 61,62,63 with char_last on 63; 3 next pulses.
//  3 No match: N=3, done with match=0 -> res_match=0, pos=0, no char phase, back to IDLE, job_ready=1.
//  4 Timeout: TIMEOUT_CYCLES=16, done never asserts -> res_timeout=1 after exactly 16 WAIT cycles.
//  5 Errors: str_len=20 and str_len=448 -> res_error=1, proc_start never pulses.
//    Also N=0 -> no bytes accepted, result still reported.
//  6 Stress: res_ready/char_ready low 5 cycles -> outputs stable; stale proc_done=1 at START ignored;
//    reset mid-FEED -> in_ready=0 next cycle, IDLE.

Source files
------------

// File: rtl/md5_job_sequencer_if.sv
// Job, byte-stream, matcher, result and char-stream bundle around the
// MD5 job sequencer; slave is the sequencer's view, master its neighbours'.
interface md5_job_sequencer_if;
   logic         job_valid;
   logic         job_ready;
   logic [15:0]  job_num_bytes;
   logic [15:0]  job_str_len;
   logic [127:0] job_target_hash;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         proc_start;
   logic [15:0]  proc_num_bytes;
   logic [15:0]  proc_str_len;
   logic [127:0] proc_target_hash;
   logic [7:0]   proc_data;
   logic         proc_data_valid;
   logic         proc_match_char_next;
   logic         proc_done;
   logic         proc_match;
   logic [15:0]  proc_byte_pos;
   logic [7:0]   proc_match_char;
   logic         res_valid;
   logic         res_ready;
   logic         res_match;
   logic         res_timeout;
   logic         res_error;
   logic [15:0]  res_byte_pos;
   logic [7:0]   char_data;
   logic         char_valid;
   logic         char_ready;
   logic         char_last;

   modport slave (
      input  job_valid, job_num_bytes, job_str_len, job_target_hash,
      input  in_data, in_valid,
      input  proc_done, proc_match, proc_byte_pos, proc_match_char,
      input  res_ready, char_ready,
      output job_ready, in_ready,
      output proc_start, proc_num_bytes, proc_str_len, proc_target_hash,
      output proc_data, proc_data_valid, proc_match_char_next,
      output res_valid, res_match, res_timeout, res_error, res_byte_pos,
      output char_data, char_valid, char_last
   );

   modport master (
      output job_valid, job_num_bytes, job_str_len, job_target_hash,
      output in_data, in_valid,
      output proc_done, proc_match, proc_byte_pos, proc_match_char,
      output res_ready, char_ready,
      input  job_ready, in_ready,
      input  proc_start, proc_num_bytes, proc_str_len, proc_target_hash,
      input  proc_data, proc_data_valid, proc_match_char_next,
      input  res_valid, res_match, res_timeout, res_error, res_byte_pos,
      input  char_data, char_valid, char_last
   );
endinterface

// File: rtl/md5_job_sequencer.sv
// Runs one hash-search job through the matcher: start, feed bytes,
// wait for done with timeout, report the result, stream the matched string.
module md5_job_sequencer #(
   parameter int MAX_STR_BYTES  = 55,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic                clk,
   input logic                reset,
   md5_job_sequencer_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [15:0]   MAX_BITS  = 16'(MAX_STR_BYTES * 8);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_GUARD, S_FEED, S_WAIT, S_REPORT, S_CHARS
   } state_t;

   state_t state, state_nxt;

   logic [15:0]   num_bytes_q;
   logic [15:0]   str_len_q;
   logic [127:0]  hash_q;
   logic [15:0]   byte_cnt;
   logic [TW-1:0] wait_cnt;
   logic [12:0]   char_cnt;
   logic          match_q;
   logic          timeout_q;
   logic          error_q;
   logic [15:0]   pos_q;
   logic          gap_q;

   logic in_rdy;
   logic char_vld;
   logic in_hs;
   logic char_hs;
   logic bad_len;
   logic last_byte;
   logic last_char;
   logic wait_expired;

   assign in_rdy       = (state == S_FEED);
   assign char_vld     = (state == S_CHARS) && !gap_q;
   assign in_hs        = bus.in_valid & in_rdy;
   assign char_hs      = char_vld & bus.char_ready;
   assign bad_len      = (bus.job_str_len == 16'd0) ||
                         (bus.job_str_len[2:0] != 3'd0) ||
                         (bus.job_str_len > MAX_BITS);
   assign last_byte    = (byte_cnt == num_bytes_q - 16'd1);
   assign last_char    = (char_cnt == str_len_q[15:3] - 13'd1);
   assign wait_expired = (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // proc_done is a level left over from the previous job, so it is
   // only honoured once WAIT is reached.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (bus.job_valid)
                      state_nxt = bad_len ? S_REPORT : S_START;
         S_START:  state_nxt = S_GUARD;
         S_GUARD:  state_nxt = (num_bytes_q == 16'd0) ? S_WAIT : S_FEED;
         S_FEED:   if (in_hs && last_byte) state_nxt = S_WAIT;
         S_WAIT:   if (bus.proc_done || wait_expired) state_nxt = S_REPORT;
         S_REPORT: if (bus.res_ready)
                      state_nxt = match_q ? S_CHARS : S_IDLE;
         S_CHARS:  if (char_hs && last_char) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         num_bytes_q <= '0;
         str_len_q   <= '0;
         hash_q      <= '0;
         byte_cnt    <= '0;
         wait_cnt    <= '0;
         char_cnt    <= '0;
         match_q     <= 1'b0;
         timeout_q   <= 1'b0;
         error_q     <= 1'b0;
         pos_q       <= '0;
         gap_q       <= 1'b0;
      end else begin
         if (state == S_IDLE && bus.job_valid) begin
            num_bytes_q <= bus.job_num_bytes;
            str_len_q   <= bus.job_str_len;
            hash_q      <= bus.job_target_hash;
            match_q     <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= bad_len;
            pos_q       <= '0;
         end
         if (state == S_WAIT) begin
            if (bus.proc_done) begin
               match_q <= bus.proc_match;
               pos_q   <= bus.proc_match ? bus.proc_byte_pos : 16'd0;
            end else if (wait_expired) begin
               timeout_q <= 1'b1;
            end
         end
         byte_cnt <= in_rdy ? byte_cnt + {15'd0, in_hs} : 16'd0;
         wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
         char_cnt <= (state == S_CHARS) ? char_cnt + {12'd0, char_hs}
                                        : 13'd0;
         gap_q    <= char_hs;
      end
   end

   assign bus.proc_num_bytes   = num_bytes_q;
   assign bus.proc_str_len     = str_len_q;
   assign bus.proc_target_hash = hash_q;
   assign bus.proc_data        = bus.in_data;

   always_comb begin
      bus.job_ready            = 1'b0;
      bus.proc_start           = 1'b0;
      bus.in_ready             = 1'b0;
      bus.proc_data_valid      = 1'b0;
      bus.res_valid            = 1'b0;
      bus.res_match            = 1'b0;
      bus.res_timeout          = 1'b0;
      bus.res_error            = 1'b0;
      bus.res_byte_pos         = 16'd0;
      bus.char_valid           = 1'b0;
      bus.char_data            = 8'd0;
      bus.char_last            = 1'b0;
      bus.proc_match_char_next = 1'b0;
      unique case (state)
         S_IDLE:  bus.job_ready = 1'b1;
         S_START: bus.proc_start = 1'b1;
         S_FEED: begin
            bus.in_ready        = 1'b1;
            bus.proc_data_valid = bus.in_valid;
         end
         S_REPORT: begin
            bus.res_valid    = 1'b1;
            bus.res_match    = match_q;
            bus.res_timeout  = timeout_q;
            bus.res_error    = error_q;
            bus.res_byte_pos = pos_q;
         end
         S_CHARS: begin
            bus.char_valid           = char_vld;
            bus.char_data            = bus.proc_match_char;
            bus.char_last            = char_vld & last_char;
            bus.proc_match_char_next = char_hs;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_md5_job_sequencer.sv
// Random and directed jobs against a job-level model of the sequencer,
// with a stub matcher, a byte source and a result/char consumer.
module tb_md5_job_sequencer;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;

   md5_job_sequencer_if bus ();

   md5_job_sequencer #(
      .MAX_STR_BYTES (55),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // current job and its expected outcome
   logic [15:0]  j_n, j_len, j_pos;
   logic [127:0] j_hash;
   logic [7:0]   j_chars[$];
   bit           e_start, e_match, e_tmo, e_err;
   logic [15:0]  e_pos;
   int           e_bytes, e_nchars;

   // observations
   int  c_start, c_bytes, c_next, c_res, c_char, c_quiet;
   bit  seen_start, seen_res, prev_char_hs, job_complete, job_done;
   bit  got_match, got_tmo, got_err;
   logic [15:0] got_pos;
   logic [7:0]  got_chars[$];

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic rand_chars(input logic [15:0] len);
      j_chars.delete();
      for (int i = 0; i < int'(len / 16'd8) && i < 64; i++)
         j_chars.push_back(8'($urandom_range(32, 126)));
   endtask

   always begin
      @(negedge clk);
      #2;
      if (!reset) begin
         check("data_valid", bus.proc_data_valid, bus.in_valid & bus.in_ready);
         if (bus.proc_data_valid) begin
            check("proc_data", bus.proc_data, bus.in_data);
            c_bytes++;
         end
         check("job_ready_excl", bus.job_ready & (bus.in_ready |
               bus.res_valid | bus.char_valid | bus.proc_start), 1'b0);
         if (bus.proc_start) begin
            c_start++;
            seen_start = 1'b1;
            check("cfg_num", bus.proc_num_bytes, j_n);
            check("cfg_len", bus.proc_str_len, j_len);
            check("cfg_hash", bus.proc_target_hash, j_hash);
         end else if (seen_start && !seen_res && !bus.job_ready &&
                      !bus.in_ready && !bus.res_valid && !bus.char_valid) begin
            c_quiet++;
         end
         if (bus.res_valid) begin
            if (!seen_res && e_tmo) check("tmo_latency", c_quiet, TMO + 1);
            seen_res = 1'b1;
            check("res_match", bus.res_match, e_match);
            check("res_timeout", bus.res_timeout, e_tmo);
            check("res_error", bus.res_error, e_err);
            check("res_pos", bus.res_byte_pos, e_pos);
            if (bus.res_ready) begin
               c_res++;
               got_match = bus.res_match;
               got_tmo   = bus.res_timeout;
               got_err   = bus.res_error;
               got_pos   = bus.res_byte_pos;
               if (e_nchars == 0) job_complete = 1'b1;
            end
         end
         if (prev_char_hs) check("char_gap", bus.char_valid, 1'b0);
         check("next_pulse", bus.proc_match_char_next,
               bus.char_valid & bus.char_ready);
         if (bus.proc_match_char_next) c_next++;
         prev_char_hs = bus.char_valid & bus.char_ready;
         if (bus.char_valid) begin
            check("char_in_range", c_char < e_nchars, 1'b1);
            if (c_char < e_nchars) begin
               check("char_data", bus.char_data, j_chars[c_char]);
               check("char_last", bus.char_last, c_char == e_nchars - 1);
            end
            if (bus.char_ready) begin
               got_chars.push_back(bus.char_data);
               c_char++;
               if (c_char == e_nchars) job_complete = 1'b1;
            end
         end
      end
   end

   task automatic run_job(input logic [15:0] n, input logic [15:0] len,
                          input bit m, input logic [15:0] pos,
                          input bit tmo, input int dly, input bit hold);
      j_n = n;
      j_len = len;
      j_pos = pos;
      j_hash = {$urandom, $urandom, $urandom, $urandom};
      e_err = (len == 16'd0) || (len % 16'd8 != 16'd0) || (len > 16'd440);
      e_start = !e_err;
      e_bytes = e_err ? 0 : int'(n);
      e_tmo = !e_err && tmo;
      e_match = !e_err && !tmo && m;
      e_pos = e_match ? pos : 16'd0;
      e_nchars = e_match ? int'(len / 16'd8) : 0;
      c_start = 0; c_bytes = 0; c_next = 0; c_res = 0; c_char = 0;
      c_quiet = 0;
      seen_start = 0; seen_res = 0; prev_char_hs = 0;
      job_complete = 0; job_done = 0;
      got_match = 0; got_tmo = 0; got_err = 0; got_pos = '0;
      got_chars.delete();
      fork
         begin : host
            int k;
            k = 0;
            @(negedge clk);
            bus.job_valid = 1'b1;
            bus.job_num_bytes = n;
            bus.job_str_len = len;
            bus.job_target_hash = j_hash;
            #1;
            while (!bus.job_ready && k < 50) begin
               @(negedge clk);
               #1;
               k++;
            end
            check("job_accept", bus.job_ready, 1'b1);
            @(negedge clk);
            bus.job_valid = 1'b0;
            bus.job_num_bytes = 16'($urandom);
            bus.job_str_len = 16'($urandom);
            bus.job_target_hash = {$urandom, $urandom, $urandom, $urandom};
         end
         begin : feeder
            while (!job_done) begin
               @(negedge clk);
               bus.in_valid = ($urandom_range(0, 3) != 0);
               bus.in_data = 8'($urandom);
            end
            bus.in_valid = 1'b0;
         end
         begin : matcher
            int ph, d, head;
            bit shift;
            ph = 0; d = dly; head = 0; shift = 0;
            while (!job_done) begin
               @(negedge clk);
               case (ph)
                  0: if (bus.proc_start) ph = 1;
                  1: begin
                     bus.proc_done = 1'b0;
                     head = 0;
                     shift = 0;
                     ph = 2;
                  end
                  2: if (c_bytes == int'(n)) begin
                     if (d == 0) begin
                        if (!tmo) begin
                           bus.proc_done = 1'b1;
                           bus.proc_match = m;
                           bus.proc_byte_pos = pos;
                        end
                        ph = 3;
                     end else d--;
                  end
                  default: ;
               endcase
               if (shift) begin
                  head++;
                  shift = 0;
               end
               bus.proc_match_char = (head < j_chars.size()) ? j_chars[head]
                                                             : 8'h00;
               #1;
               if (bus.proc_match_char_next) shift = 1;
            end
         end
         begin : consumer
            int k, hr, hc;
            bit hr_set, hc_set;
            k = 0; hr = 0; hc = 0; hr_set = 0; hc_set = 0;
            forever begin
               @(negedge clk);
               if (job_complete) break;
               if (k >= 3000) begin
                  check("job_complete_bound", job_complete, 1'b1);
                  break;
               end
               k++;
               if (hold && bus.res_valid && !hr_set) begin hr = 5; hr_set = 1; end
               if (hold && bus.char_valid && !hc_set) begin hc = 5; hc_set = 1; end
               bus.res_ready = (hr > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
               bus.char_ready = (hc > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
               if (hr > 0) hr--;
               if (hc > 0) hc--;
            end
            bus.res_ready = 1'b0;
            bus.char_ready = 1'b0;
            job_done = 1'b1;
         end
      join
      check("starts", c_start, e_start);
      check("bytes", c_bytes, e_bytes);
      check("results", c_res, 1);
      check("chars", c_char, e_nchars);
      check("next_pulses", c_next, e_nchars);
      if (!job_complete) begin
         reset = 1'b1;
         repeat (2) @(negedge clk);
         reset = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] n, len, pos;
      bit m, tmo, hold;
      int dly, r;
      bus.job_valid = 0; bus.job_num_bytes = 0; bus.job_str_len = 0;
      bus.job_target_hash = 0; bus.in_data = 0; bus.in_valid = 0;
      bus.proc_done = 0; bus.proc_match = 0; bus.proc_byte_pos = 0;
      bus.proc_match_char = 0; bus.res_ready = 0; bus.char_ready = 0;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("rst_job_ready", bus.job_ready, 1'b1);
      check("rst_proc_start", bus.proc_start, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_res_valid", bus.res_valid, 1'b0);
      check("rst_res_flags", {bus.res_match, bus.res_timeout, bus.res_error},
            3'b000);
      check("rst_res_pos", bus.res_byte_pos, 16'd0);
      check("rst_char", {bus.char_valid, bus.char_last, bus.char_data}, 10'd0);
      check("rst_next", bus.proc_match_char_next, 1'b0);
      check("rst_latched", {bus.proc_num_bytes, bus.proc_str_len,
            bus.proc_target_hash}, 160'd0);
      check("rst_data", {bus.proc_data_valid, bus.proc_data}, 9'd0);
      @(negedge clk);
      reset = 1'b0;

      j_chars = '{8'h61, 8'h62, 8'h63};
      run_job(16'd4, 16'd24, 1'b1, 16'd2, 1'b0, 2, 1'b0);
      check("abc_match", got_match, 1'b1);
      check("abc_pos", got_pos, 16'd2);
      check("abc_bytes", c_bytes, 4);
      check("abc_c0", got_chars.size() > 0 ? got_chars[0] : 8'h00, 8'h61);
      check("abc_c1", got_chars.size() > 1 ? got_chars[1] : 8'h00, 8'h62);
      check("abc_c2", got_chars.size() > 2 ? got_chars[2] : 8'h00, 8'h63);
      check("abc_next", c_next, 3);

      rand_chars(16'd32);
      run_job(16'd3, 16'd32, 1'b0, 16'd7, 1'b0, 1, 1'b0);
      check("nomatch_flag", got_match, 1'b0);
      check("nomatch_pos", got_pos, 16'd0);
      @(negedge clk);
      #2;
      check("nomatch_idle", bus.job_ready, 1'b1);

      rand_chars(16'd16);
      run_job(16'd5, 16'd16, 1'b1, 16'd1, 1'b1, 0, 1'b0);
      check("tmo_flag", got_tmo, 1'b1);
      check("tmo_quiet", c_quiet, 17);
      rand_chars(16'd8);
      run_job(16'd0, 16'd8, 1'b1, 16'd1, 1'b1, 0, 1'b0);
      check("tmo_n0_flag", got_tmo, 1'b1);

      run_job(16'd2, 16'd20, 1'b1, 16'd1, 1'b0, 0, 1'b0);
      check("err20_flag", got_err, 1'b1);
      check("err20_start", c_start, 0);
      run_job(16'd2, 16'd448, 1'b1, 16'd1, 1'b0, 0, 1'b0);
      check("err448_flag", got_err, 1'b1);
      run_job(16'd2, 16'd0, 1'b1, 16'd1, 1'b0, 0, 1'b0);
      check("err0_flag", got_err, 1'b1);

      rand_chars(16'd16);
      run_job(16'd0, 16'd16, 1'b1, 16'd9, 1'b0, 0, 1'b0);
      check("n0_bytes", c_bytes, 0);
      check("n0_pos", got_pos, 16'd9);

      rand_chars(16'd8);
      run_job(16'd2, 16'd8, 1'b1, 16'd3, 1'b0, 15, 1'b0);
      check("late_done_match", got_match, 1'b1);
      check("late_done_tmo", got_tmo, 1'b0);

      rand_chars(16'd440);
      run_job(16'd3, 16'd440, 1'b1, 16'd4, 1'b0, 1, 1'b1);
      check("max_len_chars", c_char, 55);

      for (int i = 0; i < 25; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      len = 16'($urandom);
         else if (r == 1) len = 16'(8 * $urandom_range(56, 60));
         else             len = 16'(8 * $urandom_range(1, 55));
         n = 16'($urandom_range(0, 12));
         pos = 16'($urandom);
         m = 1'($urandom_range(0, 1));
         tmo = ($urandom_range(0, 7) == 0);
         dly = $urandom_range(0, 15);
         hold = 1'($urandom_range(0, 1));
         rand_chars(len);
         run_job(n, len, m, pos, tmo, dly, hold);
      end

      j_n = 16'd50; j_len = 16'd8; j_hash = '0;
      @(negedge clk);
      bus.job_valid = 1'b1;
      bus.job_num_bytes = 16'd50;
      bus.job_str_len = 16'd8;
      bus.job_target_hash = '0;
      @(negedge clk);
      bus.job_valid = 1'b0;
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      check("pre_reset_feed", bus.in_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #2;
      check("midreset_in_ready", bus.in_ready, 1'b0);
      check("midreset_job_ready", bus.job_ready, 1'b1);
      check("midreset_latched", bus.proc_num_bytes, 16'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      rand_chars(16'd24);
      run_job(16'd6, 16'd24, 1'b1, 16'd5, 1'b0, 3, 1'b0);
      check("recover_match", got_match, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
